// File: rtl/free_list.sv
// Circular FIFO of free physical register tags feeding rename; retire-side head allows single-cycle flush recovery.
// Latency: alloc_tag/empty/free_count are combinational from state; pops, pushes and flushes take effect at the next edge.
// Backpressure: none internally; rename must stall while empty=1, and alloc_en is ignored when empty or during flush.

package free_list_pkg;
    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int PHYS_W   = $clog2(NUM_PHYS);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PHYS_W-1:0] phys_reg;
        logic              valid;
        logic              ready;
    } tag_t;
endpackage

module free_list
    import free_list_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc_en,
    output tag_t             alloc_tag,
    output logic             empty,
    input  logic             retire_en,
    input  tag_t             retire_tag,
    input  logic             flush,
    output logic [CNT_W-1:0] free_count
);

    logic [PHYS_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  retire_head_q, retire_head_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              alloc_fire;
    logic              unused_tag_bits;

    // Only the register index of a superseded tag is kept.
    assign unused_tag_bits = ^{retire_tag.valid, retire_tag.ready};

    assign empty              = (count_q == '0);
    assign free_count         = count_q;
    assign alloc_tag.phys_reg = mem_q[head_q];
    assign alloc_tag.valid    = !empty;
    assign alloc_tag.ready    = 1'b0;

    assign alloc_fire = alloc_en && !empty && !flush;

    always_comb begin
        tail_d        = tail_q;
        retire_head_d = retire_head_q;
        head_d        = head_q;
        count_d       = count_q;

        if (retire_en) begin
            tail_d        = tail_q + PTR_W'(1);
            retire_head_d = retire_head_q + PTR_W'(1);
        end

        // Flush rewinds head past every unretired allocation, including a same-cycle retire.
        if (flush) begin
            head_d  = retire_head_d;
            count_d = CNT_W'(DEPTH);
        end else begin
            if (alloc_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            if (retire_en && !alloc_fire) begin
                count_d = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
            end else if (alloc_fire && !retire_en) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            retire_head_q <= '0;
            count_q       <= CNT_W'(DEPTH);
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            retire_head_q <= retire_head_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PHYS_W'(NUM_ARCH + i);
            end
        end else if (retire_en) begin
            mem_q[tail_q] <= retire_tag.phys_reg;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic checked against a queue-based model
// (free tags in allocation order, and outstanding speculative allocations oldest first).
module tb_free_list;
    import free_list_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       alloc_en;
    tag_t       alloc_tag;
    logic       empty;
    logic       retire_en;
    tag_t       retire_tag;
    logic       flush;
    logic [5:0] free_count;

    int tests;
    int fails;
    int free_q[$];
    int spec_q[$];

    free_list dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .alloc_en   (alloc_en),
        .alloc_tag  (alloc_tag),
        .empty      (empty),
        .retire_en  (retire_en),
        .retire_tag (retire_tag),
        .flush      (flush),
        .free_count (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Illegal overflow: a retire into a full list without a compensating allocation.
    always @(posedge clock) begin
        if (reset_n && retire_en && free_count == 6'd32 && !(alloc_en && !empty && !flush)) begin
            fails++;
            $display("FAIL overflow: retire with free_count=%0d, required < 32", free_count);
        end
    end

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    endtask

    task automatic do_reset();
        alloc_en   = 1'b0;
        retire_en  = 1'b0;
        flush      = 1'b0;
        retire_tag = '0;
        reset_n    = 1'b0;
        #7;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of stimulus and advance the reference model across the edge.
    task automatic step(input logic a, input logic r, input logic [5:0] t, input logic f);
        bit fire;
        alloc_en   = a;
        retire_en  = r;
        retire_tag = '{phys_reg: t, valid: 1'b1, ready: 1'b0};
        flush      = f;
        fire       = a && !f && (free_q.size() > 0);
        @(posedge clock);
        if (r) begin
            if (spec_q.size() > 0) void'(spec_q.pop_front());
            free_q.push_back(int'(t));
        end
        if (fire) spec_q.push_back(free_q.pop_front());
        if (f) begin
            free_q = {spec_q, free_q};
            spec_q.delete();
        end
        #1;
        alloc_en  = 1'b0;
        retire_en = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        tag_t exp;
        do_reset();
        exp = '{phys_reg: 6'd32, valid: 1'b1, ready: 1'b0};
        tests++;
        if (alloc_tag !== exp) begin
            fails++; $display("FAIL reset_tag: got %h, required %h", alloc_tag, exp);
        end
        tests++;
        if (free_count !== 6'd32) begin
            fails++; $display("FAIL reset_count: got %0d, required 32", free_count);
        end
        tests++;
        if (empty !== 1'b0) begin
            fails++; $display("FAIL reset_empty: got %b, required 0", empty);
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (alloc_tag.phys_reg !== 6'(32 + i) || alloc_tag.valid !== 1'b1) begin
                fails++; $display("FAIL drain_tag[%0d]: got %0d v=%b, required %0d v=1",
                                  i, alloc_tag.phys_reg, alloc_tag.valid, 32 + i);
            end
            step(1'b1, 1'b0, 6'd0, 1'b0);
        end
        tests++;
        if (empty !== 1'b1 || alloc_tag.valid !== 1'b0 || free_count !== 6'd0) begin
            fails++; $display("FAIL drain_empty: empty=%b valid=%b count=%0d, required 1 0 0",
                              empty, alloc_tag.valid, free_count);
        end
        step(1'b1, 1'b0, 6'd0, 1'b0);
        tests++;
        if (empty !== 1'b1 || free_count !== 6'd0) begin
            fails++; $display("FAIL alloc_when_empty: empty=%b count=%0d, required 1 0", empty, free_count);
        end
    endtask

    // Continues from the drained state left by test_drain.
    task automatic test_retire_empty();
        step(1'b0, 1'b1, 6'd5, 1'b0);
        tests++;
        if (alloc_tag.phys_reg !== 6'd5 || alloc_tag.valid !== 1'b1 || free_count !== 6'd1) begin
            fails++; $display("FAIL retire_empty: tag=%0d v=%b count=%0d, required 5 1 1",
                              alloc_tag.phys_reg, alloc_tag.valid, free_count);
        end
        step(1'b1, 1'b1, 6'd7, 1'b0);
        tests++;
        if (alloc_tag.phys_reg !== 6'd7 || free_count !== 6'd1) begin
            fails++; $display("FAIL alloc_retire_same: tag=%0d count=%0d, required 7 1",
                              alloc_tag.phys_reg, free_count);
        end
    endtask

    task automatic test_flush_wrap();
        int e;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
        step(1'b0, 1'b1, 6'd2, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1);
        tests++;
        if (free_count !== 6'd32 || empty !== 1'b0) begin
            fails++; $display("FAIL flush_count: count=%0d empty=%b, required 32 0", free_count, empty);
        end
        for (int i = 0; i < 32; i++) begin
            e = (i < 31) ? 33 + i : 2;
            tests++;
            if (alloc_tag.phys_reg !== 6'(e)) begin
                fails++; $display("FAIL flush_order[%0d]: got %0d, required %0d", i, alloc_tag.phys_reg, e);
            end
            step(1'b1, 1'b0, 6'd0, 1'b0);
        end
    endtask

    task automatic test_flush_collide();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
        step(1'b1, 1'b1, 6'd9, 1'b1);
        tests++;
        if (free_count !== 6'd32 || alloc_tag.phys_reg !== 6'd33) begin
            fails++; $display("FAIL flush_collide: count=%0d tag=%0d, required 32 33",
                              free_count, alloc_tag.phys_reg);
        end
        n = 0;
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (alloc_tag.phys_reg !== 6'(free_q[0])) begin
                fails++; n++;
                $display("FAIL collide_order[%0d]: got %0d, required %0d", i, alloc_tag.phys_reg, free_q[0]);
            end
            if (i == 31 && free_q[0] != 9) $display("FAIL collide_model: last tag %0d, required 9", free_q[0]);
            step(1'b1, 1'b0, 6'd0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic a, r, f;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tests++;
            if (empty !== (free_q.size() == 0) || free_count !== 6'(free_q.size()) ||
                alloc_tag.valid !== (free_q.size() > 0) || alloc_tag.ready !== 1'b0 ||
                (free_q.size() > 0 && alloc_tag.phys_reg !== 6'(free_q[0]))) begin
                fails++;
                $display("FAIL random[%0d]: tag=%0d v=%b empty=%b count=%0d, required tag=%0d count=%0d",
                         c, alloc_tag.phys_reg, alloc_tag.valid, empty, free_count,
                         (free_q.size() > 0) ? free_q[0] : -1, free_q.size());
            end
            a = ($urandom_range(0, 99) < 60);
            r = (spec_q.size() > 0) && ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 4);
            step(a, r, 6'($urandom_range(0, 63)), f);
        end
    endtask

    task automatic test_async_reset();
        tag_t exp;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
        retire_en  = 1'b1;
        retire_tag = '{phys_reg: 6'd11, valid: 1'b1, ready: 1'b0};
        reset_n    = 1'b0;
        #2;
        exp = '{phys_reg: 6'd32, valid: 1'b1, ready: 1'b0};
        tests++;
        if (alloc_tag !== exp || free_count !== 6'd32 || empty !== 1'b0) begin
            fails++; $display("FAIL async_reset: tag=%h count=%0d empty=%b, required %h 32 0",
                              alloc_tag, free_count, empty, exp);
        end
        do_reset();
        step(1'b1, 1'b0, 6'd0, 1'b0);
        tests++;
        if (alloc_tag.phys_reg !== 6'd33 || free_count !== 6'd31) begin
            fails++; $display("FAIL post_reset_alloc: tag=%0d count=%0d, required 33 31",
                              alloc_tag.phys_reg, free_count);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset_n    = 1'b0;
        alloc_en   = 1'b0;
        retire_en  = 1'b0;
        flush      = 1'b0;
        retire_tag = '0;
        test_reset();
        test_drain();
        test_retire_empty();
        test_flush_wrap();
        test_flush_collide();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
